// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: stall-controller states, output bundle
// and the default register-address width / MUL-DIV latency.
package cpu_pkg;

    localparam int REG_ADDR_W    = 4;
    localparam int MULDIV_CYCLES = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULDIV = 2'd1,
        DRAIN  = 2'd2,
        HALT   = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_stop;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_freeze;
    } stall_ctl_t;

    localparam stall_ctl_t CTL_NONE  = '{default: 1'b0};
    // PC and IF/ID held, bubble into EX: used for load-use, drain and halt.
    localparam stall_ctl_t CTL_STALL = '{pc_stop: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0,
                                        id_ex_flush: 1'b1, ex_freeze: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID sources and the load in EX.
module load_use_detect #(
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_op1,
    input  logic [REG_ADDR_W-1:0] id_op2,
    input  logic                  id_uses_op1,
    input  logic                  id_uses_op2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  load_use
);

    // Register 0 is compared like any other register.
    assign load_use = ex_mem_read &
                      ((id_uses_op1 & (id_op1 == ex_write_reg)) |
                       (id_uses_op2 & (id_op2 == ex_write_reg)));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// branch flushes, MUL/DIV EX occupancy and HALT/error drain-and-stop.
module pipeline_stall_controller #(
    parameter int MULDIV_CYCLES = cpu_pkg::MULDIV_CYCLES,
    parameter int REG_ADDR_W    = cpu_pkg::REG_ADDR_W,
    parameter int DRAIN_CYCLES  = 3,
    parameter int CNT_W         = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_op1,
    input  logic [REG_ADDR_W-1:0] id_op2,
    input  logic                  id_uses_op1,
    input  logic                  id_uses_op2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  ex_muldiv,
    input  logic                  branch_taken,
    input  logic                  id_halt,
    input  logic                  id_error,
    output logic                  pc_stop,
    output logic                  if_id_hold,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_freeze,
    output logic                  halted,
    output logic                  error_halt,
    output logic [CNT_W-1:0]      stall_count
);

    import cpu_pkg::*;

    localparam int MCNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam int DCNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                err_pend_q, err_pend_d;
    logic                halted_q, halted_d;
    logic                error_halt_q, error_halt_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;
    logic                load_use;
    stall_ctl_t          ctl_raw, ctl;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .id_op1       (id_op1),
        .id_op2       (id_op2),
        .id_uses_op1  (id_uses_op1),
        .id_uses_op2  (id_uses_op2),
        .ex_mem_read  (ex_mem_read),
        .ex_write_reg (ex_write_reg),
        .load_use     (load_use)
    );

    always_comb begin
        state_d      = state_q;
        mcnt_d       = mcnt_q;
        dcnt_d       = dcnt_q;
        err_pend_d   = err_pend_q;
        halted_d     = halted_q;
        error_halt_d = error_halt_q;
        ctl_raw      = CTL_NONE;
        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    // Everything younger than the branch is wrong-path.
                    ctl_raw.if_id_flush = 1'b1;
                    ctl_raw.id_ex_flush = 1'b1;
                end else if (id_error) begin
                    ctl_raw.pc_stop     = 1'b1;
                    ctl_raw.id_ex_flush = 1'b1;
                    state_d             = DRAIN;
                    dcnt_d              = DCNT_W'(DRAIN_CYCLES - 1);
                    err_pend_d          = 1'b1;
                end else if (id_halt) begin
                    ctl_raw    = CTL_STALL;
                    state_d    = DRAIN;
                    dcnt_d     = DCNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    if (load_use) ctl_raw = CTL_STALL;
                    if (ex_muldiv) begin
                        state_d = MULDIV;
                        mcnt_d  = MCNT_W'(MULDIV_CYCLES - 2);
                    end
                end
            end
            MULDIV: begin
                ctl_raw.pc_stop    = 1'b1;
                ctl_raw.if_id_hold = 1'b1;
                ctl_raw.ex_freeze  = 1'b1;
                if (mcnt_q == '0) state_d = RUN;
                else              mcnt_d  = mcnt_q - MCNT_W'(1);
            end
            DRAIN: begin
                ctl_raw = CTL_STALL;
                if (dcnt_q == '0) begin
                    state_d      = HALT;
                    halted_d     = 1'b1;
                    error_halt_d = err_pend_q;
                end else begin
                    dcnt_d = dcnt_q - DCNT_W'(1);
                end
            end
            HALT: begin
                ctl_raw = CTL_STALL;
            end
            default: state_d = RUN;
        endcase
    end

    assign ctl = reset ? ctl_raw : CTL_NONE;

    always_comb begin
        stall_count_d = stall_count_q;
        if (ctl.pc_stop && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= RUN;
            mcnt_q        <= '0;
            dcnt_q        <= '0;
            err_pend_q    <= 1'b0;
            halted_q      <= 1'b0;
            error_halt_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mcnt_q        <= mcnt_d;
            dcnt_q        <= dcnt_d;
            err_pend_q    <= err_pend_d;
            halted_q      <= halted_d;
            error_halt_q  <= error_halt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pc_stop     = ctl.pc_stop;
    assign if_id_hold  = ctl.if_id_hold;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_flush = ctl.id_ex_flush;
    assign ex_freeze   = ctl.ex_freeze;
    assign halted      = halted_q;
    assign error_halt  = error_halt_q;
    assign stall_count = stall_count_q;

endmodule
